// File: rtl/fsk_byte_rx.sv
// FSK byte receiver: turns offset-free FSK samples into UART-style bytes.
// A zero-crossing half-period detector recovers the mark/space bit stream
// (RXD). A frame engine then locks onto the start bit, samples each bit near
// its centre, and reports each received byte with an ok or error pulse.
module fsk_byte_rx #(
    parameter int SPB = 64,   // sample strobes per bit (even, 8..255)
    parameter int TH  = 6     // half-period length separating mark from space
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ce_Fd,
    input  logic [11:0] DFSK_SH,
    output logic        RXD,
    output logic        ce_rx_bit,
    output logic        en_rx,
    output logic [7:0]  rx_dat,
    output logic        ok_rx,
    output logic        err_rx,
    output logic        no_car
);

    localparam logic [7:0] TH_L      = 8'(TH);
    localparam logic [7:0] HALF_LAST = 8'(SPB / 2 - 1);
    localparam logic [7:0] BIT_LAST  = 8'(SPB - 1);
    localparam logic [7:0] HP_MAX    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Demodulator state
    logic       w_sign;
    logic       w_unused;
    logic       r_sign;
    logic [7:0] r_hpCnt;
    logic       r_rxd;
    logic       r_noCar;

    // Frame engine state
    state_t     r_state;
    state_t     w_stateNext;
    logic [7:0] r_cb;
    logic [7:0] w_cbNext;
    logic [3:0] r_bitN;
    logic [3:0] w_bitNNext;
    logic [7:0] r_shift;
    logic [7:0] w_shiftNext;
    logic       r_armed;
    logic       w_armedNext;
    logic       r_enRx;
    logic       w_enRxNext;
    logic [7:0] r_rxDat;
    logic [7:0] w_rxDatNext;
    logic       r_bitPulse;
    logic       w_bitPulse;
    logic       r_okPulse;
    logic       w_okPulse;
    logic       r_errPulse;
    logic       w_errPulse;

    // Only the sign of the sample matters to a zero-crossing detector.
    assign w_sign   = DFSK_SH[11];
    assign w_unused = ^DFSK_SH[10:0];

    // Half-period measurement: a crossing closes the current half-period and
    // classifies it as mark (short) or space (long); a long silence with no
    // crossing means the carrier is gone and the bit decision is frozen.
    always_ff @(posedge clk) begin
        if (res) begin
            r_sign  <= 1'b0;
            r_hpCnt <= 8'd0;
            r_rxd   <= 1'b1;
            r_noCar <= 1'b0;
        end else if (ce_Fd) begin
            if (w_sign != r_sign) begin
                r_rxd   <= (r_hpCnt < TH_L);
                r_hpCnt <= 8'd1;
                r_noCar <= 1'b0;
                r_sign  <= w_sign;
            end else if (r_hpCnt != HP_MAX) begin
                r_hpCnt <= r_hpCnt + 8'd1;
                if (r_hpCnt == HP_MAX - 8'd1) begin
                    r_noCar <= 1'b1;
                end
            end
        end
    end

    // Frame engine next-state logic: hunt for a start edge once the line has
    // been seen idle (armed), confirm the start bit at its centre, then sample
    // the data and stop bits one bit period apart.
    always_comb begin
        w_stateNext = r_state;
        w_cbNext    = r_cb;
        w_bitNNext  = r_bitN;
        w_shiftNext = r_shift;
        w_armedNext = r_armed;
        w_enRxNext  = r_enRx;
        w_rxDatNext = r_rxDat;
        w_bitPulse  = 1'b0;
        w_okPulse   = 1'b0;
        w_errPulse  = 1'b0;

        if (r_noCar && (r_state != IDLE)) begin
            w_stateNext = IDLE;
            w_cbNext    = 8'd0;
            w_enRxNext  = 1'b0;
            w_armedNext = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_rxd) begin
                        w_armedNext = 1'b1;
                    end else if (r_armed) begin
                        w_stateNext = START;
                        w_cbNext    = 8'd0;
                    end
                end
                START: begin
                    if (r_cb == HALF_LAST) begin
                        w_bitPulse = 1'b1;
                        w_cbNext   = 8'd0;
                        if (!r_rxd) begin
                            w_stateNext = DATA;
                            w_enRxNext  = 1'b1;
                            w_bitNNext  = 4'd0;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_cbNext = r_cb + 8'd1;
                    end
                end
                DATA: begin
                    if (r_cb == BIT_LAST) begin
                        w_bitPulse  = 1'b1;
                        w_shiftNext = {r_rxd, r_shift[7:1]};
                        w_bitNNext  = r_bitN + 4'd1;
                        w_cbNext    = 8'd0;
                        if (r_bitN == 4'd7) begin
                            w_stateNext = STOP;
                        end
                    end else begin
                        w_cbNext = r_cb + 8'd1;
                    end
                end
                STOP: begin
                    if (r_cb == BIT_LAST) begin
                        w_bitPulse  = 1'b1;
                        w_cbNext    = 8'd0;
                        w_enRxNext  = 1'b0;
                        w_stateNext = IDLE;
                        if (r_rxd) begin
                            w_rxDatNext = r_shift;
                            w_okPulse   = 1'b1;
                        end else begin
                            w_errPulse  = 1'b1;
                            w_armedNext = 1'b0;
                        end
                    end else begin
                        w_cbNext = r_cb + 8'd1;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_cbNext    = 8'd0;
                end
            endcase
        end
    end

    // Frame engine registers: advance only on sample strobes; the status
    // pulses last exactly one clock because any non-strobe cycle clears them.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state    <= IDLE;
            r_cb       <= 8'd0;
            r_bitN     <= 4'd0;
            r_shift    <= 8'd0;
            r_armed    <= 1'b0;
            r_enRx     <= 1'b0;
            r_rxDat    <= 8'd0;
            r_bitPulse <= 1'b0;
            r_okPulse  <= 1'b0;
            r_errPulse <= 1'b0;
        end else if (ce_Fd) begin
            r_state    <= w_stateNext;
            r_cb       <= w_cbNext;
            r_bitN     <= w_bitNNext;
            r_shift    <= w_shiftNext;
            r_armed    <= w_armedNext;
            r_enRx     <= w_enRxNext;
            r_rxDat    <= w_rxDatNext;
            r_bitPulse <= w_bitPulse;
            r_okPulse  <= w_okPulse;
            r_errPulse <= w_errPulse;
        end else begin
            r_bitPulse <= 1'b0;
            r_okPulse  <= 1'b0;
            r_errPulse <= 1'b0;
        end
    end

    assign RXD       = r_rxd;
    assign no_car    = r_noCar;
    assign ce_rx_bit = r_bitPulse;
    assign en_rx     = r_enRx;
    assign rx_dat    = r_rxDat;
    assign ok_rx     = r_okPulse;
    assign err_rx    = r_errPulse;

endmodule

// File: tb/tb_fsk_byte_rx.sv
// Testbench for fsk_byte_rx: synthesises a phase-continuous FSK waveform
// (mark = 4-strobe half-periods, space = 8), frames bytes UART-style and
// compares the receiver's pulses and data against a frame-level model.
module tb_fsk_byte_rx;

    localparam int SPB = 64;
    localparam int TH  = 6;
    localparam int CLK_PER_STROBE = 4;

    logic        clk = 1'b0;
    logic        res;
    logic        ce_Fd;
    logic [11:0] DFSK_SH;
    logic        RXD;
    logic        ce_rx_bit;
    logic        en_rx;
    logic [7:0]  rx_dat;
    logic        ok_rx;
    logic        err_rx;
    logic        no_car;

    int compareCnt  = 0;
    int mismatchCnt = 0;

    // Monitor tallies
    int   bitPulseCnt  = 0;
    int   okCnt        = 0;
    int   errCnt       = 0;
    int   enHighCnt    = 0;
    int   overlapCnt   = 0;
    int   widePulseCnt = 0;
    logic prevOk       = 1'b0;
    logic prevErr      = 1'b0;
    logic prevBit      = 1'b0;

    // Waveform generator state
    bit   curSign  = 1'b0;
    bit   lastSign = 1'b0;
    int   halfCnt  = 0;
    int   amp      = 1000;

    // Frame-level model: the last byte that completed with a good stop bit
    logic [7:0] expRxDat = 8'h00;

    fsk_byte_rx #(.SPB(SPB), .TH(TH)) dut (
        .clk       (clk),
        .res       (res),
        .ce_Fd     (ce_Fd),
        .DFSK_SH   (DFSK_SH),
        .RXD       (RXD),
        .ce_rx_bit (ce_rx_bit),
        .en_rx     (en_rx),
        .rx_dat    (rx_dat),
        .ok_rx     (ok_rx),
        .err_rx    (err_rx),
        .no_car    (no_car)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Output monitor sampling just after each rising edge: counts pulses,
    // en_rx-high cycles, ok/err overlap and pulses wider than one clock.
    always @(posedge clk) begin
        #1;
        if (ce_rx_bit === 1'b1) bitPulseCnt++;
        if (ok_rx === 1'b1) okCnt++;
        if (err_rx === 1'b1) errCnt++;
        if (en_rx === 1'b1) enHighCnt++;
        if ((ok_rx === 1'b1) && (err_rx === 1'b1)) overlapCnt++;
        if (((ok_rx === 1'b1) && prevOk) || ((err_rx === 1'b1) && prevErr) ||
            ((ce_rx_bit === 1'b1) && prevBit)) widePulseCnt++;
        prevOk  = (ok_rx === 1'b1);
        prevErr = (err_rx === 1'b1);
        prevBit = (ce_rx_bit === 1'b1);
    end

    // Watchdog so the run always ends
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCnt++;
        assert (observed === expected) else begin
            mismatchCnt++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One sample strobe; called and returns on a falling clock edge
    task automatic strobeOnce(input logic [11:0] sample);
        ce_Fd   = 1'b1;
        DFSK_SH = sample;
        @(negedge clk);
        ce_Fd   = 1'b0;
        repeat (CLK_PER_STROBE - 1) @(negedge clk);
    endtask

    // Send nStrobes of a mark (b=1) or space (b=0) tone
    task automatic applyStimulus(input bit b, input int nStrobes);
        int halfLen;
        halfLen = b ? 4 : 8;
        for (int i = 0; i < nStrobes; i++) begin
            strobeOnce(curSign ? 12'(-amp) : 12'(amp));
            lastSign = curSign;
            halfCnt++;
            if (halfCnt >= halfLen) begin
                curSign = ~curSign;
                halfCnt = 0;
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput($sformatf("%s RXD", tag), RXD, 1);
        checkOutput($sformatf("%s ce_rx_bit", tag), ce_rx_bit, 0);
        checkOutput($sformatf("%s en_rx", tag), en_rx, 0);
        checkOutput($sformatf("%s rx_dat", tag), rx_dat, 0);
        checkOutput($sformatf("%s ok_rx", tag), ok_rx, 0);
        checkOutput($sformatf("%s err_rx", tag), err_rx, 0);
        checkOutput($sformatf("%s no_car", tag), no_car, 0);
    endtask

    // Send one complete frame and compare against what the frame should yield
    task automatic runFrame(input logic [7:0] d, input bit stopGood, input string tag);
        int b0;
        int o0;
        int e0;
        int h0;
        b0 = bitPulseCnt;
        o0 = okCnt;
        e0 = errCnt;
        h0 = enHighCnt;
        applyStimulus(1'b0, SPB);
        for (int i = 0; i < 8; i++) applyStimulus(d[i], SPB);
        applyStimulus(stopGood, SPB);
        if (stopGood) expRxDat = d;
        checkOutput($sformatf("%s bitPulses", tag), bitPulseCnt - b0, 10);
        checkOutput($sformatf("%s okPulses", tag), okCnt - o0, stopGood ? 1 : 0);
        checkOutput($sformatf("%s errPulses", tag), errCnt - e0, stopGood ? 0 : 1);
        checkOutput($sformatf("%s enRxCycles", tag), enHighCnt - h0, 9 * SPB * CLK_PER_STROBE);
        checkOutput($sformatf("%s rx_dat", tag), rx_dat, expRxDat);
    endtask

    // Directed scenarios followed by randomized frames
    initial begin
        int b0;
        int o0;
        int e0;
        int h0;
        logic [11:0] holdVal;
        bit holdSign;
        logic [7:0] d;
        bit good;
        bit lastErr;
        int gap;

        res     = 1'b1;
        ce_Fd   = 1'b0;
        DFSK_SH = 12'd0;
        repeat (3) @(negedge clk);
        checkResetState("por");
        res = 1'b0;
        $display("[TB] reset done");

        // Clean frame, then a bad stop bit, then recovery after a mark
        applyStimulus(1'b1, 2 * SPB);
        runFrame(8'hA5, 1'b1, "a5");
        applyStimulus(1'b1, SPB);
        runFrame(8'hA5, 1'b0, "a5BadStop");
        applyStimulus(1'b1, SPB);
        runFrame(8'h5A, 1'b1, "5a");

        // Short space burst: start is checked and rejected
        applyStimulus(1'b1, SPB);
        b0 = bitPulseCnt; o0 = okCnt; e0 = errCnt; h0 = enHighCnt;
        applyStimulus(1'b0, 16);
        applyStimulus(1'b1, 2 * SPB);
        checkOutput("glitch bitPulses", bitPulseCnt - b0, 1);
        checkOutput("glitch enRxCycles", enHighCnt - h0, 0);
        checkOutput("glitch okPulses", okCnt - o0, 0);
        checkOutput("glitch errPulses", errCnt - e0, 0);
        checkOutput("glitch rx_dat", rx_dat, expRxDat);
        runFrame(8'h3C, 1'b1, "3cAfterGlitch");

        // Carrier loss in the middle of a frame
        applyStimulus(1'b1, SPB);
        checkOutput("noCar idle", no_car, 0);
        o0 = okCnt; e0 = errCnt;
        applyStimulus(1'b0, SPB);
        applyStimulus(1'b1, SPB);
        applyStimulus(1'b0, SPB);
        checkOutput("noCar enRxMidFrame", en_rx, 1);
        holdSign = ~lastSign;
        holdVal  = holdSign ? 12'(-300) : 12'(300);
        repeat (254) strobeOnce(holdVal);
        checkOutput("noCar after254", no_car, 0);
        strobeOnce(holdVal);
        checkOutput("noCar after255", no_car, 1);
        repeat (45) strobeOnce(holdVal);
        checkOutput("noCar held", no_car, 1);
        checkOutput("noCar enRx", en_rx, 0);
        checkOutput("noCar okPulses", okCnt - o0, 0);
        checkOutput("noCar errPulses", errCnt - e0, 0);
        lastSign = holdSign;
        curSign  = ~holdSign;
        halfCnt  = 0;
        applyStimulus(1'b1, 1);
        checkOutput("noCar cleared", no_car, 0);
        applyStimulus(1'b1, 2 * SPB - 1);
        runFrame(8'($urandom), 1'b1, "afterNoCar");

        // Reset in the middle of data bit 4; the tail of that frame is all mark
        applyStimulus(1'b1, SPB);
        d = 8'hF0 | 8'($urandom_range(0, 15));
        o0 = okCnt; e0 = errCnt;
        applyStimulus(1'b0, SPB);
        for (int i = 0; i < 4; i++) applyStimulus(d[i], SPB);
        applyStimulus(1'b1, 20);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        checkResetState("midReset");
        expRxDat = 8'h00;
        applyStimulus(1'b1, SPB - 20);
        applyStimulus(1'b1, 3 * SPB);
        applyStimulus(1'b1, 2 * SPB);
        checkOutput("midReset okPulses", okCnt - o0, 0);
        checkOutput("midReset errPulses", errCnt - e0, 0);
        checkOutput("midReset rx_dat", rx_dat, expRxDat);
        runFrame(8'h3C, 1'b1, "3cAfterReset");

        // Back-to-back frames with no idle gap
        applyStimulus(1'b1, SPB);
        runFrame(8'h00, 1'b1, "b2b00");
        runFrame(8'hFF, 1'b1, "b2bFF");

        // Randomized frames: random byte, amplitude, gap and stop-bit quality
        lastErr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            gap = lastErr ? $urandom_range(1, 2) : $urandom_range(0, 2);
            applyStimulus(1'b1, gap * SPB);
            amp  = $urandom_range(100, 2047);
            d    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            runFrame(d, good, $sformatf("rand%0d", k));
            lastErr = ~good;
        end
        applyStimulus(1'b1, SPB);

        checkOutput("okErrOverlap", overlapCnt, 0);
        checkOutput("pulseWidth", widePulseCnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
        $finish;
    end

endmodule

// File: doc/fsk_byte_rx.md
Name: fsk_byte_rx

Overview:
- FSK byte receiver: the receive end of the FSK byte link, taking the offset-removed FSK samples (DFSK_SH) and the sample strobe (ce_Fd) from the amplitude/offset measurement stage.
- Demodulates mark/space by measuring half-period length between zero crossings, then deframes UART-style bytes: 1 start bit (space), 8 data bits LSB first, 1 stop bit (mark).
- Delivers each received byte with a ready/error pulse.

Parameters:
- SPB, 64, ce_Fd strobes per bit; even, 8..255.
- TH, 6, half-period threshold in strobes: a half-period shorter than TH is mark (1), TH or longer is space (0).

Ports:
- clk  in  1  system clock.
- res  in  1  reset, synchronous, active-high.
- ce_Fd  in  1  sample strobe, one clk wide; all state advances only when ce_Fd=1.
- DFSK_SH  in  12  offset-removed FSK sample, two's complement.
- RXD  out  1  demodulated bit stream.
- ce_rx_bit  out  1  one-clk pulse at each mid-bit sample instant (start, data, stop).
- en_rx  out  1  high while a confirmed frame is being received.
- rx_dat  out  8  last correctly received byte.
- ok_rx  out  1  one-clk pulse: rx_dat updated.
- err_rx  out  1  one-clk pulse: frame error (stop bit = space).
- no_car  out  1  carrier absent (no zero crossing for 255 strobes).

Behaviour:
- Reset (res=1 at clk edge, takes priority over ce_Fd): RXD=1, ce_rx_bit=0, en_rx=0, rx_dat=0, ok_rx=0, err_rx=0, no_car=0. FSM goes to IDLE, not armed. hp_cnt=0, bit counter=0, shift register=0, stored sign=0.
- Demodulator, per ce_Fd:
  - Sign s=DFSK_SH[11]; hp_cnt is 8 bits and saturates at 255.
  - If s differs from the stored sign: RXD <= (hp_cnt < TH), hp_cnt <= 1, no_car <= 0, store s.
  - Otherwise: hp_cnt <= hp_cnt+1 (saturating). When it reaches 255, no_car <= 1 and RXD holds its value.
  - RXD latency: it updates on the strobe of the crossing that ends a half-period.
- Frame FSM, per ce_Fd; cb counts strobes within a bit.
  - IDLE:
    - RXD=1 sets armed.
    - armed and RXD=0 -> START, cb=0.
  - START:
    - cb increments each strobe.
    - At cb=SPB/2-1: ce_rx_bit pulse.
      - RXD=0 -> DATA, en_rx=1, cb=0, bit index n=0.
      - RXD=1 -> IDLE, armed stays set (glitch rejected, no en_rx).
  - DATA:
    - At cb=SPB-1: ce_rx_bit pulse, shift RXD into bit 7 of the shift register (so LSB ends at bit 0 after 8 shifts), n++, cb=0.
    - After n=8 -> STOP.
  - STOP:
    - At cb=SPB-1: ce_rx_bit pulse.
      - RXD=1: rx_dat <= shift register, ok_rx pulse.
      - RXD=0: err_rx pulse, rx_dat unchanged, armed cleared.
    - en_rx=0 the same cycle; go to IDLE.
- Back-to-back frames: a start edge right after a good stop is accepted, since armed stays set after a good stop.
- no_car=1 in any state except IDLE -> IDLE, en_rx=0, armed cleared, no ok/err pulse.
- ok_rx and err_rx never assert together. Each pulse is exactly one clk wide, coincident with a ce_Fd cycle.
- ce_Fd=0: all registers hold; pulses are 0.

Test Plan:
- Byte 0xA5 framed, SPB=64, mark half-period 4 strobes, space half-period 8, ce_Fd every 4 clk, amplitude ±1000 -> exactly 10 ce_rx_bit pulses, en_rx high from start confirmation to stop sample, then rx_dat=0xA5, one ok_rx pulse, err_rx=0.
- Same frame with stop bit sent as space -> err_rx single pulse, rx_dat keeps the previous value, no ok_rx. The receiver re-arms only after a mark and then receives the next byte 0x5A correctly.
- Idle mark, then 16 strobes of space, then mark -> ce_rx_bit single pulse at the START check, en_rx stays 0, no ok/err. A following 0x3C frame is received OK.
- DFSK_SH held at +300 for 300 strobes -> no_car=1 at the 255th strobe without a crossing. An FSM mid-frame returns to IDLE with no ok/err. no_car clears on the first crossing.
- res asserted during DATA bit 4 of a frame -> all outputs take reset values on the next clk. The remainder of that frame gives no ok_rx. The next full frame 0x3C gives rx_dat=0x3C.
- Back-to-back 0x00 then 0xFF with no idle gap -> two ok_rx pulses, rx_dat=0x00 then 0xFF.
